// File: rtl/workers_debug_pkg.sv
// Shared types and constants for the workers debug action arbiter.
// Stats counters are built only with WORKERS_DBG_ARB_STATS_EN defined.
package workers_debug_pkg;

   localparam int JDO_W_DEF  = 38;
   localparam int CODE_W_DEF = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2
   } arb_state_e;

   localparam logic [2:0] BREAK_A   = 3'd0;
   localparam logic [2:0] BREAK_B   = 3'd1;
   localparam logic [2:0] BREAK_C   = 3'd2;
   localparam logic [2:0] OCIMEM_A  = 3'd3;
   localparam logic [2:0] OCIMEM_B  = 3'd4;
   localparam logic [2:0] TRACECTRL = 3'd5;

endpackage

// File: rtl/workers_debug_rr_pick.sv
// Combinational round-robin search: first pending index after last_i,
// wrapping modulo N.
module workers_debug_rr_pick
   import workers_debug_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   pend_i,
   input  logic [IDW-1:0] last_i,
   output logic [IDW-1:0] idx_o,
   output logic           found_o
);

   // Walk farthest-first so the nearest pending slot is written last.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (pend_i[(int'(last_i) + k) % N]) begin
            found_o = 1'b1;
            idx_o   = IDW'((int'(last_i) + k) % N);
         end
      end
   end

endmodule

// File: rtl/workers_debug_action_arbiter.sv
// Round-robin arbiter of debug-slave actions onto one req/ack bus.
// Optional drop counters: define WORKERS_DBG_ARB_STATS_EN.
module workers_debug_action_arbiter
   import workers_debug_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int JDO_W   = JDO_W_DEF,
   parameter int CODE_W  = CODE_W_DEF,
   parameter int TMO_W   = 6
`ifdef WORKERS_DBG_ARB_STATS_EN
   ,
   parameter int CNT_W   = 8
`endif
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*CODE_W-1:0]   req_code,
   input  logic [NUM_REQ*JDO_W-1:0]    req_jdo,
   output logic [NUM_REQ-1:0]          req_pending,
   output logic [NUM_REQ-1:0]          req_drop,
   output logic                        bus_req,
   output logic [$clog2(NUM_REQ)-1:0]  bus_id,
   output logic [CODE_W-1:0]           bus_code,
   output logic [JDO_W-1:0]            bus_jdo,
   input  logic                        bus_ack,
   output logic                        bus_timeout,
   output logic                        busy
`ifdef WORKERS_DBG_ARB_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0]    drop_cnt
`endif
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

   logic [NUM_REQ-1:0] valid_q;
   logic [NUM_REQ-1:0] drop_q;
   logic [CODE_W-1:0]  code_q [NUM_REQ];
   logic [JDO_W-1:0]   jdo_q  [NUM_REQ];

   arb_state_e         state_q;
   logic [IDW-1:0]     last_q;
   logic [TMO_W-1:0]   tmo_q;
   logic               bus_req_q;
   logic [IDW-1:0]     bus_id_q;
   logic [CODE_W-1:0]  bus_code_q;
   logic [JDO_W-1:0]   bus_jdo_q;
   logic               bus_tmo_q;
   logic               busy_q;

   logic               done;
   logic [NUM_REQ-1:0] rel;
   logic [IDW-1:0]     pick;
   logic               found;

   workers_debug_rr_pick #(
      .N   (NUM_REQ),
      .IDW (IDW)
   ) u_pick (
      .pend_i  (valid_q),
      .last_i  (last_q),
      .idx_o   (pick),
      .found_o (found)
   );

   // Ack and timeout both end the issue and free the granted slot.
   assign done = (state_q == S_ISSUE) && (bus_ack || tmo_q == TMO_MAX);

   always_comb begin
      rel = '0;
      if (done) rel[bus_id_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q <= '0;
         drop_q  <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            code_q[i] <= '0;
            jdo_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && (!valid_q[i] || rel[i])) begin
               valid_q[i] <= 1'b1;
               code_q[i]  <= req_code[i*CODE_W +: CODE_W];
               jdo_q[i]   <= req_jdo[i*JDO_W +: JDO_W];
            end else if (rel[i]) begin
               valid_q[i] <= 1'b0;
            end
         end
         drop_q <= req_valid & valid_q & ~rel;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         last_q     <= IDW'(NUM_REQ - 1);
         tmo_q      <= '0;
         bus_req_q  <= 1'b0;
         bus_id_q   <= '0;
         bus_code_q <= '0;
         bus_jdo_q  <= '0;
         bus_tmo_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         bus_tmo_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (found) begin
                  state_q    <= S_ISSUE;
                  bus_req_q  <= 1'b1;
                  busy_q     <= 1'b1;
                  bus_id_q   <= pick;
                  bus_code_q <= code_q[pick];
                  bus_jdo_q  <= jdo_q[pick];
                  last_q     <= pick;
                  tmo_q      <= '0;
               end
            end
            S_ISSUE: begin
               if (bus_ack) begin
                  state_q   <= S_GAP;
                  bus_req_q <= 1'b0;
               end else if (tmo_q == TMO_MAX) begin
                  state_q   <= S_GAP;
                  bus_req_q <= 1'b0;
                  bus_tmo_q <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_GAP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q   <= S_IDLE;
               bus_req_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign req_pending = valid_q;
   assign req_drop    = drop_q;
   assign bus_req     = bus_req_q;
   assign bus_id      = bus_id_q;
   assign bus_code    = bus_code_q;
   assign bus_jdo     = bus_jdo_q;
   assign bus_timeout = bus_tmo_q;
   assign busy        = busy_q;

`ifdef WORKERS_DBG_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_q [NUM_REQ];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!reset_n) begin
            cnt_q[i] <= '0;
         end else if (drop_q[i] && cnt_q[i] != {CNT_W{1'b1}}) begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      drop_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         drop_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end
`endif

endmodule

// File: doc/workers_debug_action_arbiter.md
# workers_debug_action_arbiter

Round-robin arbiter that shares one debug configuration bus between `NUM_REQ` worker-CPU debug slaves. Each requester's sysclk-side debug-slave action pulses, decoded as an action code plus the 38-bit `jdo` payload, are latched into a one-deep pending slot. They are then granted in turn onto a single req/ack write bus that drives the shared breakpoint and trace configuration logic. The block sits in the workers subsystem, between the per-CPU debug slave wrappers and the shared debug register block.

## Interface
- `NUM_REQ`, 4, number of requesting debug slaves (2..8)
- `JDO_W`, 38, payload width
- `CODE_W`, 3, action code width
- `TMO_W`, 6, ack timeout counter width
- `CNT_W`, 8, drop counter width (used only with stats)
- `clk`  in  1  single system clock
- `reset_n`  in  1  reset; synchronous and active-low
- `req_valid`  in  NUM_REQ  one-cycle action pulse per requester
- `req_code`  in  NUM_REQ*CODE_W  action code, sampled with `req_valid`
- `req_jdo`  in  NUM_REQ*JDO_W  payload, sampled with `req_valid`
- `req_pending`  out  NUM_REQ  slot occupied
- `req_drop`  out  NUM_REQ  one-cycle pulse: request lost because the slot was full
- `bus_req`  out  1  write request to the shared bus
- `bus_id`  out  $clog2(NUM_REQ)  granted requester index
- `bus_code`  out  CODE_W  granted code
- `bus_jdo`  out  JDO_W  granted payload
- `bus_ack`  in  1  bus completion; valid only while `bus_req` is high
- `bus_timeout`  out  1  one-cycle pulse when an issue is aborted
- `busy`  out  1  FSM not in IDLE
- `drop_cnt`  out  NUM_REQ*CNT_W  per-requester drop counters (present only with `WORKERS_DBG_ARB_STATS_EN`)

## Operation
- **Pending slot per requester.** Each slot holds a valid bit, a code and a payload.
  - `req_valid` with the slot empty: the slot is loaded.
  - `req_valid` with the slot full and not being released this cycle: the request is ignored and `req_drop[i]` pulses on the next cycle.
  - Release and new valid in the same cycle: the slot is reloaded; no drop.
- **FSM states:** IDLE, ISSUE, GAP.
  - IDLE: if any slot is pending, pick the first pending index searching from `last+1` upward, wrapping modulo `NUM_REQ`. Register `bus_id`, `bus_code` and `bus_jdo` from that slot, set `last` to the index and go to ISSUE.
  - ISSUE: `bus_req`=1 and the payload is held stable.
    - `bus_ack`=1: release the granted slot and go to GAP.
    - Timeout counter reaches 2^TMO_W−1 without ack: release the slot, pulse `bus_timeout` and go to GAP.
  - GAP: one idle cycle with `bus_req`=0, then go to IDLE.
- **Timeout counter.** Cleared on entry to ISSUE and incremented each ISSUE cycle. If ack and timeout coincide, the ack wins and there is no `bus_timeout` pulse.
- **Payload sampling.** The slot contents are copied into the bus registers at grant. A later refill of the same slot does not disturb an issue in progress.
- **`busy`** is high in ISSUE and GAP.

## Timing
- **Reset values:**
  - `req_pending`, `req_drop`, `bus_req`, `bus_timeout` and `busy` are 0.
  - `bus_id`, `bus_code` and `bus_jdo` are 0.
  - `last` is `NUM_REQ`−1, so requester 0 is granted first.
  - `drop_cnt` is 0.
- **Grant latency:** `req_valid` at cycle t, `req_pending` at t+1, `bus_req` at t+2 when the FSM is IDLE.
- **Release:** ack at cycle k gives `bus_req`=0 and the slot cleared at k+1 (GAP), IDLE at k+2, and the next `bus_req` at k+3. Minimum issue period is 3 cycles with immediate ack.
- **Timeout:** with no ack, `bus_req` stays high for exactly 2^TMO_W cycles; `bus_timeout` is coincident with the first GAP cycle.
- **Reset mid-issue:** `bus_req` drops on the next edge. No ack is required afterwards, and any ack seen while `bus_req`=0 is ignored.
- **Fairness:** with all requesters continuously pending, grants rotate 0,1,…,NUM_REQ−1,0.

## Configuration
- `WORKERS_DBG_ARB_STATS_EN` defined: the `drop_cnt` port exists. Each counter increments on its `req_drop` pulse and saturates at 2^CNT_W−1.
- Not defined: the port and counters are absent. All other behaviour is identical.

## Structure
- Shared package `workers_debug_pkg`:
  - FSM state enum (IDLE/ISSUE/GAP).
  - Action code constants: BREAK_A/B/C, OCIMEM_A/B, TRACECTRL.
  - Default `JDO_W`/`CODE_W`.
- One sub-module `workers_debug_rr_pick`: a combinational round-robin priority search, taking the pending mask and `last` and producing the index and a found flag.

## Test plan
- Reset, then a single `req_valid[2]` with code 3 and jdo 0x12_3456_789A at cycle 5 → `bus_req`=1 at cycle 7 with `bus_id`=2, code 3, that jdo. Ack at 9 → `req_pending[2]`=0 at 10.
- All four requesters pulse in the same cycle with ack tied high → grant order 0,1,2,3, with `bus_req` rising edges 3 cycles apart.
- Requester 1 pulses twice while its slot is pending and not granted → one `req_drop[1]` pulse. With the macro, `drop_cnt[1]`=1; after 300 drops it holds at 255.
- ack held low, `TMO_W`=6 → `bus_req` high for 64 cycles, `bus_timeout` pulse, slot cleared, next pending requester granted.
- New `req_valid[0]` in the same cycle as the ack of requester 0 → no drop, slot refilled, and it is issued again after the other pending requesters.
- `reset_n` low during ISSUE → all outputs return to reset values next edge; the first grant after reset goes to requester 0.
